// File: rtl/inj_patgen_pkg.sv
// Shared types for the multi-channel injection pattern generator.
package inj_patgen_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARMED = 3'd1,
    DELAY = 3'd2,
    HIGH  = 3'd3,
    LOW   = 3'd4
  } state_e;

  localparam logic [1:0] REG_DELAY  = 2'd0;
  localparam logic [1:0] REG_HIGH   = 2'd1;
  localparam logic [1:0] REG_PERIOD = 2'd2;
  localparam logic [1:0] REG_COUNT  = 2'd3;

endpackage

// File: rtl/inj_patgen_ch.sv
// One pattern-generator channel: shadow config, phase/pulse counters, FSM.
module inj_patgen_ch
  import inj_patgen_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             res_n,
  input  logic             rst,
  input  logic             suspend,
  input  logic             start,
  input  logic             synced,
  input  logic             sync_rise,
  input  logic [CNT_W-1:0] cfg_delay,
  input  logic [CNT_W-1:0] cfg_high,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_count,
  output logic             out,
  output logic             running,
  output logic             done
);

  typedef logic [CNT_W-1:0] cnt_t;

  state_e state, state_nxt;
  cnt_t   sh_delay, sh_high, sh_period, sh_count;
  cnt_t   sh_delay_nxt, sh_high_nxt, sh_period_nxt, sh_count_nxt;
  cnt_t   phase_cnt, phase_nxt, pulse_cnt, pulse_nxt;
  logic   done_nxt;
  cnt_t   hl, ll, c_hl, c_ll;
  logic   last, last_nxt, c_last;

  // High phase is clipped to the period, so high>=period leaves no LOW phase.
  function automatic cnt_t high_len(cnt_t h, cnt_t p);
    return (h >= p) ? p : h;
  endfunction

  // First state of a pulse; a final pulse with a single LOW cycle ends immediately.
  function automatic state_e pulse_entry(cnt_t h, cnt_t l, logic fin);
    if (h != '0) return HIGH;
    if (fin && (l == cnt_t'(1))) return IDLE;
    return LOW;
  endfunction

  assign hl       = high_len(sh_high, sh_period);
  assign ll       = sh_period - hl;
  assign c_hl     = high_len(cfg_high, cfg_period);
  assign c_ll     = cfg_period - c_hl;
  assign last     = (sh_count != '0) && (pulse_cnt == sh_count - cnt_t'(1));
  assign last_nxt = (sh_count >= cnt_t'(2)) && (pulse_cnt == sh_count - cnt_t'(2));
  assign c_last   = (cfg_count == cnt_t'(1));

  always_comb begin
    state_nxt     = state;
    phase_nxt     = phase_cnt;
    pulse_nxt     = pulse_cnt;
    sh_delay_nxt  = sh_delay;
    sh_high_nxt   = sh_high;
    sh_period_nxt = sh_period;
    sh_count_nxt  = sh_count;
    done_nxt      = 1'b0;
    if (rst) begin
      state_nxt = IDLE;
      phase_nxt = '0;
      pulse_nxt = '0;
    end else if (suspend) begin
      state_nxt = state;
    end else if (start && (cfg_period != '0)) begin
      sh_delay_nxt  = cfg_delay;
      sh_high_nxt   = cfg_high;
      sh_period_nxt = cfg_period;
      sh_count_nxt  = cfg_count;
      phase_nxt     = '0;
      pulse_nxt     = '0;
      if (synced) begin
        state_nxt = ARMED;
      end else if (cfg_delay != '0) begin
        state_nxt = DELAY;
      end else begin
        state_nxt = pulse_entry(c_hl, c_ll, c_last);
        done_nxt  = (state_nxt == IDLE);
      end
    end else begin
      case (state)
        ARMED: if (sync_rise) begin
          if (sh_delay != '0) begin
            state_nxt = DELAY;
          end else begin
            state_nxt = pulse_entry(hl, ll, last);
            done_nxt  = (state_nxt == IDLE);
          end
        end
        DELAY: if (phase_cnt == sh_delay - cnt_t'(1)) begin
          phase_nxt = '0;
          state_nxt = pulse_entry(hl, ll, last);
          done_nxt  = (state_nxt == IDLE);
        end else begin
          phase_nxt = phase_cnt + cnt_t'(1);
        end
        HIGH: if (phase_cnt == hl - cnt_t'(1)) begin
          phase_nxt = '0;
          if ((ll == '0) && !last) begin
            if (sh_count != '0) pulse_nxt = pulse_cnt + cnt_t'(1);
            state_nxt = pulse_entry(hl, ll, last_nxt);
            done_nxt  = (state_nxt == IDLE);
          end else if (last && (ll <= cnt_t'(1))) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end else begin
            state_nxt = LOW;
          end
        end else begin
          phase_nxt = phase_cnt + cnt_t'(1);
        end
        // The final LOW phase gives its last cycle to the done/IDLE cycle.
        LOW: if (last && (phase_cnt == ll - cnt_t'(2))) begin
          phase_nxt = '0;
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end else if (phase_cnt == ll - cnt_t'(1)) begin
          phase_nxt = '0;
          if (sh_count != '0) pulse_nxt = pulse_cnt + cnt_t'(1);
          state_nxt = pulse_entry(hl, ll, last_nxt);
          done_nxt  = (state_nxt == IDLE);
        end else begin
          phase_nxt = phase_cnt + cnt_t'(1);
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state     <= IDLE;
      phase_cnt <= '0;
      pulse_cnt <= '0;
      sh_delay  <= '0;
      sh_high   <= '0;
      sh_period <= '0;
      sh_count  <= '0;
      out       <= 1'b0;
      running   <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      phase_cnt <= phase_nxt;
      pulse_cnt <= pulse_nxt;
      sh_delay  <= sh_delay_nxt;
      sh_high   <= sh_high_nxt;
      sh_period <= sh_period_nxt;
      sh_count  <= sh_count_nxt;
      out       <= (state_nxt == HIGH);
      running   <= (state_nxt != IDLE);
      done      <= done_nxt;
    end
  end

endmodule

// File: rtl/inj_patgen_multi.sv
// Multi-channel injection pattern generator: byte-wide config writes, sync edge, channels.
// Optional PATGEN_TRIGOUT_EN adds trig_out, a pulse after any output rising edge.
module inj_patgen_multi
  import inj_patgen_pkg::*;
#(
  parameter  int unsigned NUM_CH = 4,
  parameter  int unsigned CNT_W  = 16,
  localparam int unsigned CH_W   = $clog2(NUM_CH),
  localparam int unsigned BYTE_W = $clog2(CNT_W / 8),
  localparam int unsigned ADDR_W = CH_W + 2 + BYTE_W
) (
  input  logic              clk,
  input  logic              res_n,
  input  logic              rst,
  input  logic              suspend,
  input  logic              write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        din,
  input  logic [NUM_CH-1:0] synced,
  input  logic [NUM_CH-1:0] start,
  input  logic              sync_trig,
  output logic [NUM_CH-1:0] out,
  output logic [NUM_CH-1:0] running,
  output logic [NUM_CH-1:0] done
`ifdef PATGEN_TRIGOUT_EN
  ,
  output logic              trig_out
`endif
);

  localparam int unsigned NBYTES = CNT_W / 8;

  logic [CNT_W-1:0] cfg_delay  [NUM_CH];
  logic [CNT_W-1:0] cfg_high   [NUM_CH];
  logic [CNT_W-1:0] cfg_period [NUM_CH];
  logic [CNT_W-1:0] cfg_count  [NUM_CH];
  logic [31:0]      addr_ext, ch_sel, byte_sel;
  logic [1:0]       reg_sel;
  logic             sync_q, sync_rise;

  // Arithmetic decode keeps zero-width channel/byte fields legal.
  assign addr_ext = 32'(addr);
  assign ch_sel   = addr_ext >> (2 + BYTE_W);
  assign reg_sel  = 2'(addr_ext >> BYTE_W);
  assign byte_sel = addr_ext & ((32'd1 << BYTE_W) - 32'd1);

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        cfg_delay[c]  <= '0;
        cfg_high[c]   <= '0;
        cfg_period[c] <= '0;
        cfg_count[c]  <= '0;
      end
    end else if (write) begin
      for (int c = 0; c < NUM_CH; c++) begin
        for (int b = 0; b < NBYTES; b++) begin
          if ((ch_sel == 32'(c)) && (byte_sel == 32'(b))) begin
            case (reg_sel)
              REG_DELAY:  cfg_delay[c][8*b +: 8]  <= din;
              REG_HIGH:   cfg_high[c][8*b +: 8]   <= din;
              REG_PERIOD: cfg_period[c][8*b +: 8] <= din;
              default:    cfg_count[c][8*b +: 8]  <= din;
            endcase
          end
        end
      end
    end
  end

  // Edge detector keeps tracking through suspend and soft reset.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) sync_q <= 1'b0;
    else        sync_q <= sync_trig;
  end
  assign sync_rise = sync_trig & ~sync_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    inj_patgen_ch #(.CNT_W(CNT_W)) u_ch (
      .clk        (clk),
      .res_n      (res_n),
      .rst        (rst),
      .suspend    (suspend),
      .start      (start[g]),
      .synced     (synced[g]),
      .sync_rise  (sync_rise),
      .cfg_delay  (cfg_delay[g]),
      .cfg_high   (cfg_high[g]),
      .cfg_period (cfg_period[g]),
      .cfg_count  (cfg_count[g]),
      .out        (out[g]),
      .running    (running[g]),
      .done       (done[g])
    );
  end

`ifdef PATGEN_TRIGOUT_EN
  logic [NUM_CH-1:0] out_q;

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      out_q    <= '0;
      trig_out <= 1'b0;
    end else begin
      out_q    <= out;
      trig_out <= |(out & ~out_q);
    end
  end
`endif

endmodule

// File: tb/tb_inj_patgen_multi.sv
// Scoreboard bench for inj_patgen_multi (NUM_CH=4, CNT_W=16).
module tb_inj_patgen_multi;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned ADDR_W = 5;

  logic              clk = 1'b0;
  logic              res_n, rst, suspend, write, sync_trig;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        din;
  logic [NUM_CH-1:0] synced, start, out, running, done;
`ifdef PATGEN_TRIGOUT_EN
  logic              trig_out;
`endif

  typedef struct packed { logic o; logic r; logic d; } exp_t;
  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  inj_patgen_multi #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .res_n     (res_n),
    .rst       (rst),
    .suspend   (suspend),
    .write     (write),
    .addr      (addr),
    .din       (din),
    .synced    (synced),
    .start     (start),
    .sync_trig (sync_trig),
    .out       (out),
    .running   (running),
    .done      (done)
`ifdef PATGEN_TRIGOUT_EN
    ,
    .trig_out  (trig_out)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_reg(input int ch, input int r, input int val);
    for (int b = 0; b < 2; b++) begin
      write = 1'b1;
      addr  = ADDR_W'(ch * 8 + r * 2 + b);
      din   = 8'(val >> (8 * b));
      step();
    end
    write = 1'b0;
  endtask

  task automatic cfg_ch(input int ch, input int dl, input int hi, input int pe, input int co);
    wr_reg(ch, 0, dl);
    wr_reg(ch, 1, hi);
    wr_reg(ch, 2, pe);
    wr_reg(ch, 3, co);
  endtask

  task automatic pulse_start(input logic [NUM_CH-1:0] m);
    start = m;
    step();
    start = '0;
  endtask

  task automatic test_reset();
    res_n = 1'b0; rst = 1'b0; suspend = 1'b0; write = 1'b0; sync_trig = 1'b0;
    addr = '0; din = '0; synced = '0; start = '0;
    repeat (3) step();
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (out !== 4'b0) $display("FAIL reset_out phase=%0d got %b required 0000", i, out);
      else n_pass++;
      n_checks++;
      if (running !== 4'b0) $display("FAIL reset_running phase=%0d got %b required 0000", i, running);
      else n_pass++;
      n_checks++;
      if (done !== 4'b0) $display("FAIL reset_done phase=%0d got %b required 0000", i, done);
      else n_pass++;
      res_n = 1'b1;
      repeat (2) step();
    end
  endtask

  task automatic test_basic();
    exp_t e, a;
    cfg_ch(0, 0, 2, 5, 3);
    repeat (2) step();
    for (int k = 1; k <= 17; k++)
      exp_q.push_back('{o: (k inside {1, 2, 6, 7, 11, 12}), r: (k <= 14), d: (k == 15)});
    pulse_start(4'b0001);
    for (int k = 1; exp_q.size() > 0; k++) begin
      e = exp_q.pop_front();
      a = '{o: out[0], r: running[0], d: done[0]};
      n_checks++;
      if (a !== e) $display("FAIL basic k=%0d got o/r/d=%b required %b", k, a, e);
      else n_pass++;
      step();
    end
  endtask

  task automatic test_synced();
    exp_t e, a;
    cfg_ch(1, 3, 1, 4, 1);
    synced = 4'b0010;
    for (int k = 1; k <= 25; k++) exp_q.push_back('{o: 1'b0, r: 1'b1, d: 1'b0});
    pulse_start(4'b0010);
    for (int k = 1; exp_q.size() > 0; k++) begin
      e = exp_q.pop_front();
      a = '{o: out[1], r: running[1], d: done[1]};
      n_checks++;
      if (a !== e) $display("FAIL synced_armed k=%0d got o/r/d=%b required %b", k, a, e);
      else n_pass++;
      step();
    end
    for (int j = 0; j <= 8; j++) exp_q.push_back('{o: (j == 4), r: (j <= 6), d: (j == 7)});
    sync_trig = 1'b1;
    for (int j = 0; exp_q.size() > 0; j++) begin
      e = exp_q.pop_front();
      a = '{o: out[1], r: running[1], d: done[1]};
      n_checks++;
      if (a !== e) $display("FAIL synced_edge j=%0d got o/r/d=%b required %b", j, a, e);
      else n_pass++;
      step();
      if (j == 1) sync_trig = 1'b0;
    end
    synced = '0;
  endtask

  task automatic test_infinite();
    exp_t e, a;
    logic seen_done;
    cfg_ch(2, 0, 1, 2, 0);
    for (int k = 1; k <= 20; k++) exp_q.push_back('{o: (k % 2 == 1), r: 1'b1, d: 1'b0});
    pulse_start(4'b0100);
    for (int k = 1; exp_q.size() > 0; k++) begin
      e = exp_q.pop_front();
      a = '{o: out[2], r: running[2], d: done[2]};
      n_checks++;
      if (a !== e) $display("FAIL infinite k=%0d got o/r/d=%b required %b", k, a, e);
      else n_pass++;
      step();
    end
    seen_done = 1'b0;
    repeat (1000) begin
      seen_done |= done[2];
      step();
    end
    n_checks++;
    if (seen_done !== 1'b0) $display("FAIL infinite_no_done got %b required 0", seen_done);
    else n_pass++;
    exp_q.push_back('{o: 1'b0, r: 1'b0, d: 1'b0});
    rst = 1'b1;
    step();
    rst = 1'b0;
    e = exp_q.pop_front();
    a = '{o: out[2], r: running[2], d: done[2]};
    n_checks++;
    if (a !== e) $display("FAIL infinite_rst got o/r/d=%b required %b", a, e);
    else n_pass++;
  endtask

  task automatic test_suspend();
    exp_t e, a;
    for (int k = 1; k <= 24; k++)
      exp_q.push_back('{o: (k <= 9 || k inside {13, 14, 18, 19}), r: (k <= 21), d: (k == 22)});
    pulse_start(4'b0001);
    for (int k = 1; exp_q.size() > 0; k++) begin
      if (k == 1) suspend = 1'b1;
      if (k == 8) suspend = 1'b0;
      if (k == 10) begin write = 1'b1; addr = ADDR_W'(4); din = 8'd9; end
      if (k == 11) begin addr = ADDR_W'(5); din = 8'd0; end
      if (k == 12) write = 1'b0;
      e = exp_q.pop_front();
      a = '{o: out[0], r: running[0], d: done[0]};
      n_checks++;
      if (a !== e) $display("FAIL suspend k=%0d got o/r/d=%b required %b", k, a, e);
      else n_pass++;
      step();
    end
    for (int k = 1; k <= 11; k++)
      exp_q.push_back('{o: (k inside {1, 2, 10, 11}), r: 1'b1, d: 1'b0});
    pulse_start(4'b0001);
    for (int k = 1; exp_q.size() > 0; k++) begin
      e = exp_q.pop_front();
      a = '{o: out[0], r: running[0], d: done[0]};
      n_checks++;
      if (a !== e) $display("FAIL new_period k=%0d got o/r/d=%b required %b", k, a, e);
      else n_pass++;
      step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_corners();
    exp_t e, a;
    for (int k = 1; k <= 4; k++) exp_q.push_back('{o: 1'b0, r: 1'b0, d: 1'b0});
    pulse_start(4'b1000);
    for (int k = 1; exp_q.size() > 0; k++) begin
      e = exp_q.pop_front();
      a = '{o: out[3], r: running[3], d: done[3]};
      n_checks++;
      if (a !== e) $display("FAIL period0 k=%0d got o/r/d=%b required %b", k, a, e);
      else n_pass++;
      step();
    end
    cfg_ch(3, 0, 0, 3, 2);
    for (int k = 1; k <= 7; k++) exp_q.push_back('{o: 1'b0, r: (k <= 5), d: (k == 6)});
    pulse_start(4'b1000);
    for (int k = 1; exp_q.size() > 0; k++) begin
      e = exp_q.pop_front();
      a = '{o: out[3], r: running[3], d: done[3]};
      n_checks++;
      if (a !== e) $display("FAIL high0 k=%0d got o/r/d=%b required %b", k, a, e);
      else n_pass++;
      step();
    end
    for (int p = 0; p < 2; p++) begin
      for (int k = 1; k <= 2; k++) exp_q.push_back('{o: 1'b0, r: 1'b0, d: 1'b0});
      if (p == 0) rst = 1'b1; else suspend = 1'b1;
      pulse_start(4'b1000);
      rst = 1'b0;
      for (int k = 1; exp_q.size() > 0; k++) begin
        e = exp_q.pop_front();
        a = '{o: out[3], r: running[3], d: done[3]};
        n_checks++;
        if (a !== e) $display("FAIL start_dropped p=%0d k=%0d got o/r/d=%b required %b", p, k, a, e);
        else n_pass++;
        step();
      end
      suspend = 1'b0;
    end
    cfg_ch(3, 0, 6, 5, 0);
    for (int k = 1; k <= 10; k++) exp_q.push_back('{o: 1'b1, r: 1'b1, d: 1'b0});
    pulse_start(4'b1000);
    for (int k = 1; exp_q.size() > 0; k++) begin
      e = exp_q.pop_front();
      a = '{o: out[3], r: running[3], d: done[3]};
      n_checks++;
      if (a !== e) $display("FAIL high_ge_period k=%0d got o/r/d=%b required %b", k, a, e);
      else n_pass++;
      step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

`ifdef PATGEN_TRIGOUT_EN
  task automatic test_trigout();
    logic [1:0] e, a;
    logic [1:0] tq[$];
    cfg_ch(0, 0, 1, 2, 1);
    cfg_ch(3, 0, 1, 2, 1);
    repeat (2) step();
    for (int k = 1; k <= 4; k++) tq.push_back({(k == 1), (k == 2)});
    pulse_start(4'b1001);
    for (int k = 1; tq.size() > 0; k++) begin
      e = tq.pop_front();
      a = {(out[0] & out[3]), trig_out};
      n_checks++;
      if (a !== e) $display("FAIL trigout k=%0d got both_out/trig=%b required %b", k, a, e);
      else n_pass++;
      step();
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_synced();
    test_infinite();
    test_suspend();
    test_corners();
`ifdef PATGEN_TRIGOUT_EN
    test_trigout();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
